rs_station: RTL and testbench
=============================

# rs_station

Parametrised reservation station for the out-of-order RISC-V core, successor to the fixed 7-slot combined station/register-status block. It holds up to RS_SIZE dispatched instructions, snoops the common data bus (CDB) to resolve source-operand tags, and issues the oldest fully-ready entry to a single downstream functional unit over a valid/ready handshake. Register renaming and the register file sit upstream; the functional unit and memory sequencer sit downstream.

## Interface
- RS_SIZE, 8: number of entries, 2..32
- TAG_W, 4: producer tag width; tag 0 means "no dependency"
- XLEN, 32: operand width
- OP_W, 17: opaque op field {fun7, fun3, opcode}, passed through unmodified
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (branch mispredict)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  station can accept a dispatch
- disp_op  in  OP_W  op field
- disp_tag  in  TAG_W  destination tag, nonzero
- disp_qj / disp_qk  in  TAG_W  source tags, 0 = value valid
- disp_vj / disp_vk  in  XLEN  source values, meaningful when the matching tag is 0
- disp_imm  in  XLEN  immediate
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_W  producing tag
- cdb_value  in  XLEN  result
- iss_valid  out  1  an entry is ready to issue
- iss_ready  in  1  functional unit accepts
- iss_op / iss_tag / iss_vj / iss_vk / iss_imm  out  widths as dispatch  selected entry
- count  out  $clog2(RS_SIZE+1)  occupied entries

## Operation
- Entry state: valid, op, tag, qj, vj, qk, vk, imm, plus an RS_SIZE×RS_SIZE age matrix (row i bit j = entry i older than entry j).
- Dispatch fires when disp_valid && disp_ready. The data is written into the lowest-index free entry, and the age-matrix row and column are updated so the new entry is youngest.
- Dispatch-time bypass: if cdb_valid, cdb_tag≠0 and disp_qj==cdb_tag, the entry stores qj=0 and vj=cdb_value. The same rule applies independently to qk/vk.
- Wake-up: each cycle, every valid entry whose qj (or qk) equals a nonzero cdb_tag under cdb_valid clears that tag and latches cdb_value. cdb_tag 0 is ignored.
- Ready = valid && qj==0 && qk==0, evaluated on registered state only.
- Select: iss_valid = any entry ready. The iss_* outputs are combinational from the oldest ready entry and stay stable while iss_valid && !iss_ready, unless a strictly older entry becomes ready.
- Issue fires when iss_valid && iss_ready. The selected entry is freed at that edge.
- disp_ready = (count < RS_SIZE). A full station does not accept a dispatch in a cycle where an issue frees an entry; there is no pass-through.
- count rules: +1 on dispatch, -1 on issue, unchanged when both occur in the same cycle.
- Flush: at the edge, all valid bits and count clear. A dispatch in the same cycle is dropped. An issue handshake in the same cycle still counts as taken by the functional unit.
- Reset takes priority over flush. It clears all valid bits, the age matrix and count. After reset: disp_ready=1, iss_valid=0, count=0, iss_* data=0.

## Timing
- Dispatch with both tags 0: iss_valid can assert the cycle after the dispatch edge (1-cycle latency).
- CDB broadcast at edge t resolves the last tag: the entry is eligible for iss_valid in cycle t+1.
- Dispatch bypass has the same latency as a dispatch with tag 0.
- One dispatch and one issue per cycle maximum.
- rst or flush asserted mid-operation: state is empty from the following cycle. No partial entries remain.

## Test plan
- Reset, then dispatch tag 1 with qj=qk=0, vj=5, vk=7 -> iss_valid next cycle, iss_tag=1, iss_vj=5, iss_vk=7. With iss_ready=1, count goes 1->0.
- Dispatch tag 2 with qj=3 and tag 4 with qj=0, qk=0 -> tag 4 issues first. After CDB (tag 3, 0xABCD), tag 2 issues with vj=0xABCD one cycle later.
- Dispatch tag 5 with qk=6 in the same cycle as CDB (tag 6, 0x1234) -> no stall; issue next cycle with vk=0x1234.
- Fill all 8 entries with unresolved tags, iss_ready=0 -> disp_ready=0 and count=8. A ninth dispatch is ignored. CDB resolves entry 3 and iss_ready=1 -> it issues, count=7, disp_ready=1.
- Three ready entries dispatched in order tags 7, 8, 9, with iss_ready held low for 3 cycles -> iss_tag stays 7. Then iss_ready=1 -> issue order 7, 8, 9.
- With 4 entries valid, flush asserted together with disp_valid -> count=0, iss_valid=0 next cycle. Repeat using rst: same result, and disp_ready=1.

Source files
------------

// File: rtl/rs_station.sv
// Reservation station: RS_SIZE entries, CDB snooping for operand wake-up,
// oldest-ready-first issue to one functional unit over valid/ready.

module rs_station_entry #(
  parameter int TAG_W = 4,
  parameter int XLEN  = 32,
  parameter int OP_W  = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc,
  input  logic             free,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [TAG_W-1:0] disp_tag,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic [XLEN-1:0]  disp_vj,
  input  logic [XLEN-1:0]  disp_vk,
  input  logic [XLEN-1:0]  disp_imm,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_value,
  output logic             valid,
  output logic [OP_W-1:0]  op,
  output logic [TAG_W-1:0] tag,
  output logic [XLEN-1:0]  vj,
  output logic [XLEN-1:0]  vk,
  output logic [XLEN-1:0]  imm,
  output logic             ready
);
  logic [TAG_W-1:0] qj, qk;
  logic             cdb_hit;

  assign cdb_hit = cdb_valid && (cdb_tag != '0);
  assign ready   = valid && (qj == '0) && (qk == '0);

  // alloc only targets a free slot and free only a valid one, so they never overlap
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      op    <= '0;
      tag   <= '0;
      qj    <= '0;
      qk    <= '0;
      vj    <= '0;
      vk    <= '0;
      imm   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (alloc) begin
      valid <= 1'b1;
      op    <= disp_op;
      tag   <= disp_tag;
      imm   <= disp_imm;
      qj    <= (cdb_hit && disp_qj == cdb_tag) ? '0 : disp_qj;
      vj    <= (cdb_hit && disp_qj == cdb_tag) ? cdb_value : disp_vj;
      qk    <= (cdb_hit && disp_qk == cdb_tag) ? '0 : disp_qk;
      vk    <= (cdb_hit && disp_qk == cdb_tag) ? cdb_value : disp_vk;
    end else begin
      if (free) valid <= 1'b0;
      if (valid && cdb_hit && qj == cdb_tag) begin
        qj <= '0;
        vj <= cdb_value;
      end
      if (valid && cdb_hit && qk == cdb_tag) begin
        qk <= '0;
        vk <= cdb_value;
      end
    end
  end
endmodule

module rs_station #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = 4,
  parameter int XLEN    = 32,
  parameter int OP_W    = 17,
  parameter int CNT_W   = $clog2(RS_SIZE+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [TAG_W-1:0] disp_tag,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic [XLEN-1:0]  disp_vj,
  input  logic [XLEN-1:0]  disp_vk,
  input  logic [XLEN-1:0]  disp_imm,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_value,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [OP_W-1:0]  iss_op,
  output logic [TAG_W-1:0] iss_tag,
  output logic [XLEN-1:0]  iss_vj,
  output logic [XLEN-1:0]  iss_vk,
  output logic [XLEN-1:0]  iss_imm,
  output logic [CNT_W-1:0] count
);
  logic [RS_SIZE-1:0]              e_valid, e_rdy, free_oh, sel_oh;
  logic [RS_SIZE-1:0][OP_W-1:0]    e_op;
  logic [RS_SIZE-1:0][TAG_W-1:0]   e_tag;
  logic [RS_SIZE-1:0][XLEN-1:0]    e_vj, e_vk, e_imm;
  logic [RS_SIZE-1:0][RS_SIZE-1:0] age;
  logic                            disp_fire, iss_fire;

  assign disp_ready = (count < CNT_W'(RS_SIZE));
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign iss_valid  = |e_rdy;
  assign iss_fire   = iss_valid && iss_ready;

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
    rs_station_entry #(.TAG_W(TAG_W), .XLEN(XLEN), .OP_W(OP_W)) u_ent (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .alloc     (disp_fire && free_oh[g]),
      .free      (iss_fire && sel_oh[g]),
      .disp_op   (disp_op),
      .disp_tag  (disp_tag),
      .disp_qj   (disp_qj),
      .disp_qk   (disp_qk),
      .disp_vj   (disp_vj),
      .disp_vk   (disp_vk),
      .disp_imm  (disp_imm),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_value (cdb_value),
      .valid     (e_valid[g]),
      .op        (e_op[g]),
      .tag       (e_tag[g]),
      .vj        (e_vj[g]),
      .vk        (e_vk[g]),
      .imm       (e_imm[g]),
      .ready     (e_rdy[g])
    );
  end

  always_comb begin
    logic found;
    free_oh = '0;
    found   = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!e_valid[i] && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // An entry wins if it is ready and no other ready entry is older than it
  always_comb begin
    logic older;
    sel_oh = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      older = 1'b0;
      for (int j = 0; j < RS_SIZE; j++)
        if (j != i && e_rdy[j] && age[j][i]) older = 1'b1;
      sel_oh[i] = e_rdy[i] && !older;
    end
  end

  always_comb begin
    iss_op  = '0;
    iss_tag = '0;
    iss_vj  = '0;
    iss_vk  = '0;
    iss_imm = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (sel_oh[i]) begin
        iss_op  = iss_op  | e_op[i];
        iss_tag = iss_tag | e_tag[i];
        iss_vj  = iss_vj  | e_vj[i];
        iss_vk  = iss_vk  | e_vk[i];
        iss_imm = iss_imm | e_imm[i];
      end
    end
  end

  // New entry: its row clears (older than nobody), its column sets (everyone older than it)
  always_ff @(posedge clk) begin
    if (rst) begin
      age <= '0;
    end else if (disp_fire) begin
      for (int i = 0; i < RS_SIZE; i++)
        for (int j = 0; j < RS_SIZE; j++)
          if (free_oh[i])      age[i][j] <= 1'b0;
          else if (free_oh[j]) age[i][j] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) count <= '0;
    else              count <= count + CNT_W'(disp_fire) - CNT_W'(iss_fire);
  end
endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station: dispatch, wake-up, bypass, full, ordering, flush/reset.

module tb_rs_station;
  logic        clk = 1'b0;
  logic        rst, flush, disp_valid, disp_ready;
  logic [16:0] disp_op, iss_op;
  logic [3:0]  disp_tag, disp_qj, disp_qk, cdb_tag, iss_tag, count;
  logic [31:0] disp_vj, disp_vk, disp_imm, cdb_value, iss_vj, iss_vk, iss_imm;
  logic        cdb_valid, iss_valid, iss_ready;
  int total = 0;
  int bad = 0;

  rs_station dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_tag(disp_tag), .disp_qj(disp_qj), .disp_qk(disp_qk),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_imm(disp_imm),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_tag(iss_tag), .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_imm(iss_imm),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_disp(input logic [3:0] tag, input logic [3:0] qj, input logic [3:0] qk,
                            input logic [31:0] vj, input logic [31:0] vk);
    disp_valid = 1'b1;
    disp_tag   = tag;
    disp_qj    = qj;
    disp_qk    = qk;
    disp_vj    = vj;
    disp_vk    = vk;
    disp_op    = {13'h0, tag};
    disp_imm   = 32'h100 + {28'h0, tag};
  endtask

  task automatic drive_cdb(input logic [3:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_value = val;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    cdb_tag    = '0;
    cdb_value  = '0;
  endtask

  task automatic test_reset();
    total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL reset_disp_ready got=%0b exp=1", disp_ready); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL reset_iss_valid got=%0b exp=0", iss_valid); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (iss_tag !== 4'd0 || iss_vj !== 32'd0 || iss_imm !== 32'd0)
      begin bad++; $display("FAIL reset_iss_data got tag=%0d vj=%0h imm=%0h exp=0", iss_tag, iss_vj, iss_imm); end
  endtask

  task automatic test_basic();
    iss_ready = 1'b0;
    drive_disp(4'd1, 4'd0, 4'd0, 32'd5, 32'd7);
    step(); idle();
    total++; if (iss_valid !== 1'b1 || iss_tag !== 4'd1) begin bad++; $display("FAIL basic_issue got v=%0b tag=%0d exp v=1 tag=1", iss_valid, iss_tag); end
    total++; if (iss_vj !== 32'd5 || iss_vk !== 32'd7) begin bad++; $display("FAIL basic_vals got vj=%0d vk=%0d exp 5 7", iss_vj, iss_vk); end
    total++; if (iss_op !== 17'd1 || iss_imm !== 32'h101) begin bad++; $display("FAIL basic_op_imm got op=%0h imm=%0h exp 1 101", iss_op, iss_imm); end
    total++; if (count !== 4'd1) begin bad++; $display("FAIL basic_count1 got=%0d exp=1", count); end
    iss_ready = 1'b1;
    step(); iss_ready = 1'b0;
    total++; if (count !== 4'd0 || iss_valid !== 1'b0) begin bad++; $display("FAIL basic_count0 got cnt=%0d v=%0b exp 0 0", count, iss_valid); end
  endtask

  task automatic test_dependency();
    drive_disp(4'd2, 4'd3, 4'd0, 32'd0, 32'h11);
    step();
    drive_disp(4'd4, 4'd0, 4'd0, 32'h44, 32'h0);
    step(); idle();
    total++; if (iss_valid !== 1'b1 || iss_tag !== 4'd4) begin bad++; $display("FAIL dep_first got v=%0b tag=%0d exp v=1 tag=4", iss_valid, iss_tag); end
    total++; if (count !== 4'd2) begin bad++; $display("FAIL dep_count got=%0d exp=2", count); end
    iss_ready = 1'b1;
    step(); iss_ready = 1'b0;
    total++; if (iss_valid !== 1'b0 || count !== 4'd1) begin bad++; $display("FAIL dep_blocked got v=%0b cnt=%0d exp 0 1", iss_valid, count); end
    drive_cdb(4'd3, 32'hABCD);
    step(); idle();
    total++; if (iss_valid !== 1'b1 || iss_tag !== 4'd2) begin bad++; $display("FAIL dep_wake got v=%0b tag=%0d exp v=1 tag=2", iss_valid, iss_tag); end
    total++; if (iss_vj !== 32'hABCD || iss_vk !== 32'h11) begin bad++; $display("FAIL dep_vals got vj=%0h vk=%0h exp abcd 11", iss_vj, iss_vk); end
    iss_ready = 1'b1;
    step(); iss_ready = 1'b0;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL dep_drain got=%0d exp=0", count); end
  endtask

  task automatic test_bypass();
    drive_disp(4'd5, 4'd0, 4'd6, 32'd1, 32'd0);
    drive_cdb(4'd6, 32'h1234);
    step(); idle();
    total++; if (iss_valid !== 1'b1 || iss_tag !== 4'd5) begin bad++; $display("FAIL bypass_issue got v=%0b tag=%0d exp v=1 tag=5", iss_valid, iss_tag); end
    total++; if (iss_vk !== 32'h1234 || iss_vj !== 32'd1) begin bad++; $display("FAIL bypass_vals got vj=%0h vk=%0h exp 1 1234", iss_vj, iss_vk); end
    iss_ready = 1'b1;
    step(); iss_ready = 1'b0;
    // a zero cdb_tag must never overwrite an operand that is already valid
    drive_disp(4'd5, 4'd0, 4'd0, 32'h77, 32'h88);
    drive_cdb(4'd0, 32'hDEAD);
    step(); idle();
    total++; if (iss_vj !== 32'h77 || iss_vk !== 32'h88) begin bad++; $display("FAIL bypass_tag0 got vj=%0h vk=%0h exp 77 88", iss_vj, iss_vk); end
    iss_ready = 1'b1;
    step(); iss_ready = 1'b0;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL bypass_drain got=%0d exp=0", count); end
  endtask

  task automatic test_full();
    iss_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_disp(4'(i + 1), (i == 3) ? 4'd10 : 4'd15, 4'd0, 32'd0, 32'(i));
      step();
    end
    idle();
    total++; if (disp_ready !== 1'b0 || count !== 4'd8) begin bad++; $display("FAIL full_state got rdy=%0b cnt=%0d exp 0 8", disp_ready, count); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL full_none_ready got=%0b exp=0", iss_valid); end
    drive_disp(4'd12, 4'd0, 4'd0, 32'h9, 32'h9);
    step(); idle();
    total++; if (count !== 4'd8 || iss_valid !== 1'b0) begin bad++; $display("FAIL full_ninth got cnt=%0d v=%0b exp 8 0", count, iss_valid); end
    drive_cdb(4'd10, 32'h55);
    step(); idle();
    total++; if (iss_valid !== 1'b1 || iss_tag !== 4'd4 || iss_vj !== 32'h55)
      begin bad++; $display("FAIL full_wake got v=%0b tag=%0d vj=%0h exp 1 4 55", iss_valid, iss_tag, iss_vj); end
    iss_ready = 1'b1;
    drive_disp(4'd13, 4'd0, 4'd0, 32'h1, 32'h1);
    step(); idle(); iss_ready = 1'b0;
    total++; if (count !== 4'd7 || disp_ready !== 1'b1) begin bad++; $display("FAIL full_issue got cnt=%0d rdy=%0b exp 7 1", count, disp_ready); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL full_no_passthru got=%0b exp=0", iss_valid); end
    flush = 1'b1;
    step(); flush = 1'b0;
    total++; if (count !== 4'd0 || disp_ready !== 1'b1) begin bad++; $display("FAIL full_flush got cnt=%0d rdy=%0b exp 0 1", count, disp_ready); end
  endtask

  task automatic test_order();
    iss_ready = 1'b0;
    drive_disp(4'd1, 4'd14, 4'd0, 32'd0, 32'd0);
    step();
    drive_disp(4'd7, 4'd0, 4'd0, 32'h70, 32'd0);
    step();
    total++; if (iss_valid !== 1'b1 || iss_tag !== 4'd7) begin bad++; $display("FAIL order_first got v=%0b tag=%0d exp 1 7", iss_valid, iss_tag); end
    drive_disp(4'd8, 4'd0, 4'd0, 32'h80, 32'd0);
    step();
    total++; if (iss_tag !== 4'd7) begin bad++; $display("FAIL order_hold1 got=%0d exp=7", iss_tag); end
    drive_disp(4'd9, 4'd0, 4'd0, 32'h90, 32'd0);
    step(); idle();
    total++; if (iss_tag !== 4'd7) begin bad++; $display("FAIL order_hold2 got=%0d exp=7", iss_tag); end
    step();
    total++; if (iss_tag !== 4'd7 || iss_vj !== 32'h70 || count !== 4'd4)
      begin bad++; $display("FAIL order_hold3 got tag=%0d vj=%0h cnt=%0d exp 7 70 4", iss_tag, iss_vj, count); end
    iss_ready = 1'b1;
    step(); iss_ready = 1'b0;
    total++; if (iss_tag !== 4'd8 || count !== 4'd3) begin bad++; $display("FAIL order_second got tag=%0d cnt=%0d exp 8 3", iss_tag, count); end
    // tag 10 lands in the slot 7 vacated: lower index, but youngest
    drive_disp(4'd10, 4'd0, 4'd0, 32'hA0, 32'd0);
    step(); idle();
    total++; if (iss_tag !== 4'd8 || count !== 4'd4) begin bad++; $display("FAIL order_reuse got tag=%0d cnt=%0d exp 8 4", iss_tag, count); end
    iss_ready = 1'b1;
    step();
    total++; if (iss_tag !== 4'd9) begin bad++; $display("FAIL order_third got=%0d exp=9", iss_tag); end
    step();
    total++; if (iss_tag !== 4'd10 || iss_vj !== 32'hA0) begin bad++; $display("FAIL order_fourth got tag=%0d vj=%0h exp 10 a0", iss_tag, iss_vj); end
    step(); iss_ready = 1'b0;
    total++; if (iss_valid !== 1'b0 || count !== 4'd1) begin bad++; $display("FAIL order_drained got v=%0b cnt=%0d exp 0 1", iss_valid, count); end
  endtask

  task automatic test_flush_rst();
    for (int i = 0; i < 3; i++) begin
      drive_disp(4'(2 + i), 4'd14, 4'd0, 32'd0, 32'd0);
      step();
    end
    total++; if (count !== 4'd4) begin bad++; $display("FAIL flush_pre got=%0d exp=4", count); end
    drive_disp(4'd11, 4'd0, 4'd0, 32'h1, 32'h1);
    flush = 1'b1;
    step(); idle(); flush = 1'b0;
    total++; if (count !== 4'd0 || iss_valid !== 1'b0) begin bad++; $display("FAIL flush_clear got cnt=%0d v=%0b exp 0 0", count, iss_valid); end
    drive_cdb(4'd14, 32'h5);
    step(); idle();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL flush_no_residue got=%0b exp=0", iss_valid); end
    for (int i = 0; i < 4; i++) begin
      drive_disp(4'(2 + i), 4'd0, 4'd0, 32'(i), 32'd0);
      step();
    end
    total++; if (count !== 4'd4 || iss_valid !== 1'b1) begin bad++; $display("FAIL rst_pre got cnt=%0d v=%0b exp 4 1", count, iss_valid); end
    drive_disp(4'd11, 4'd0, 4'd0, 32'h1, 32'h1);
    rst = 1'b1;
    step(); idle(); rst = 1'b0;
    total++; if (count !== 4'd0 || iss_valid !== 1'b0 || disp_ready !== 1'b1)
      begin bad++; $display("FAIL rst_clear got cnt=%0d v=%0b rdy=%0b exp 0 0 1", count, iss_valid, disp_ready); end
    total++; if (iss_tag !== 4'd0 || iss_vj !== 32'd0) begin bad++; $display("FAIL rst_data got tag=%0d vj=%0h exp 0 0", iss_tag, iss_vj); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; iss_ready = 1'b0;
    disp_op = '0; disp_tag = '0; disp_qj = '0; disp_qk = '0;
    disp_vj = '0; disp_vk = '0; disp_imm = '0;
    idle();
    step(); step();
    rst = 1'b0;
    test_reset();
    test_basic();
    test_dependency();
    test_bypass();
    test_full();
    test_order();
    test_flush_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
